fe_issue_arbiter: RTL

Shares one pipelined function_evaluation unit between NUM_REQ requesters.
- Arbitrates among valid requests and issues at most one operation per enabled cycle into the unit.
- Tags each issued operation and routes the returned result to the requester that issued it.
- Sits between the custom-instruction front ends (or DMA agents) and a single function_evaluation instance.

---
 rtl/fe_issue_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fe_issue_arbiter.sv
// Issue arbiter sharing one pipelined function_evaluation unit among NUM_REQ requesters.
// Define FE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fe_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 14,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x_one,
    input  logic [NUM_REQ*DATA_W-1:0] req_x_two,
    input  logic [NUM_REQ*2-1:0]      req_n,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      fe_start,
    output logic [1:0]                fe_n,
    output logic [DATA_W-1:0]         fe_x_one,
    output logic [DATA_W-1:0]         fe_x_two,
    input  logic [DATA_W-1:0]         fe_result,
    input  logic                      fe_done,
    output logic                      err
);
    localparam int TAG_W   = $clog2(NUM_REQ);
    localparam int BLANK_W = $clog2(LATENCY + 2);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(LATENCY + 1);

    // Handshake: requester i transfers when req_valid[i] & req_ready[i] & clk_en.
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any;
    logic               hs;
    logic [DATA_W-1:0]  sel_x_one;
    logic [DATA_W-1:0]  sel_x_two;
    logic [1:0]         sel_n;

    logic [LATENCY:0]   pipe_v;
    logic [TAG_W-1:0]   pipe_tag [0:LATENCY];
    logic [BLANK_W-1:0] blank_cnt;
    logic               done_s;
    logic [NUM_REQ-1:0] rsp_valid_q;

`ifdef FE_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
    end
`else
    logic [TAG_W-1:0] rr_ptr;
    int               rr_idx;

    // Scan from the pointer, wrapping, and take the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(rr_idx);
            end
        end
    end
`endif

    always_comb begin
        grant     = '0;
        sel_x_one = '0;
        sel_x_two = '0;
        sel_n     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_any && grant_idx == TAG_W'(k)) begin
                grant[k]  = 1'b1;
                sel_x_one = req_x_one[k*DATA_W +: DATA_W];
                sel_x_two = req_x_two[k*DATA_W +: DATA_W];
                sel_n     = req_n[k*2 +: 2];
            end
        end
    end

    assign req_ready = (clk_en && !rst) ? grant : '0;
    assign hs        = |req_ready;
    assign rsp_valid = clk_en ? rsp_valid_q : '0;
    // Done pulses from operations killed by a reset are ignored while blanking.
    assign done_s    = fe_done && (blank_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_start    <= 1'b0;
            fe_n        <= '0;
            fe_x_one    <= '0;
            fe_x_two    <= '0;
            pipe_v      <= '0;
            for (int k = 0; k <= LATENCY; k++) pipe_tag[k] <= '0;
            blank_cnt   <= BLANK_INIT;
            rsp_valid_q <= '0;
            rsp_result  <= '0;
            err         <= 1'b0;
`ifndef FE_ARB_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else if (clk_en) begin
            fe_start <= hs;
            if (hs) begin
                fe_n     <= sel_n;
                fe_x_one <= sel_x_one;
                fe_x_two <= sel_x_two;
            end
`ifndef FE_ARB_FIXED_PRIO_EN
            if (hs) rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
            pipe_v      <= {pipe_v[LATENCY-1:0], hs};
            pipe_tag[0] <= grant_idx;
            for (int k = 1; k <= LATENCY; k++) pipe_tag[k] <= pipe_tag[k-1];
            if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;

            // The pipe head must line up with fe_done; any disagreement is sticky.
            rsp_valid_q <= '0;
            if (done_s && pipe_v[LATENCY]) begin
                rsp_valid_q[pipe_tag[LATENCY]] <= 1'b1;
                rsp_result                     <= fe_result;
            end
            if (done_s != pipe_v[LATENCY]) err <= 1'b1;
        end
    end
endmodule
